// File: rtl/decode_issue_queue.sv
// Decode-to-issue queue: circular FIFO with dual compacted push and in-order dual pop.
// Payload storage is not reset; head, tail and count are.
package Falco_pkg;

  localparam int LFST_WIDTH = 5;

  typedef logic [15:0] BHSR_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  uop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } decoded_op_t;

  typedef struct packed {
    decoded_op_t           op;
    BHSR_t                 bhsr;
    logic [LFST_WIDTH-1:0] ssid;
  } iq_entry_t;

endpackage

module decode_issue_queue
  import Falco_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in0_valid,
  input  logic                      in1_valid,
  input  decoded_op_t               in0_op,
  input  decoded_op_t               in1_op,
  input  BHSR_t                     in0_bhsr,
  input  BHSR_t                     in1_bhsr,
  input  logic [LFST_WIDTH-1:0]     in0_ssid,
  input  logic [LFST_WIDTH-1:0]     in1_ssid,
  output logic                      in_ready,
  output logic                      out0_valid,
  output logic                      out1_valid,
  output decoded_op_t               out0_op,
  output decoded_op_t               out1_op,
  output BHSR_t                     out0_bhsr,
  output BHSR_t                     out1_bhsr,
  output logic [LFST_WIDTH-1:0]     out0_ssid,
  output logic [LFST_WIDTH-1:0]     out1_ssid,
  input  logic                      out0_issue,
  input  logic                      out1_issue,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] RDY_LIM = CW'(DEPTH - 2);

  iq_entry_t     mem_q [DEPTH];
  iq_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          acc0, acc1;
  logic          pop0, pop1;
  logic [1:0]    push_n, pop_n;
  logic [PW-1:0] head_p1;
  iq_entry_t     e0, e1;

  assign in_ready   = (count_q <= RDY_LIM);
  assign out0_valid = (count_q >= CW'(1));
  assign out1_valid = (count_q >= CW'(2));
  assign count      = count_q;

  assign acc0   = in_ready & in0_valid;
  assign acc1   = in_ready & in1_valid;
  assign pop0   = out0_issue & out0_valid;
  assign pop1   = out0_issue & out1_issue & out1_valid;
  assign push_n = {1'b0, acc0} + {1'b0, acc1};
  assign pop_n  = {1'b0, pop0} + {1'b0, pop1};

  assign head_p1 = head_q + PW'(1);
  assign e0      = mem_q[head_q];
  assign e1      = mem_q[head_p1];

  assign out0_op   = e0.op;
  assign out0_bhsr = e0.bhsr;
  assign out0_ssid = e0.ssid;
  assign out1_op   = e1.op;
  assign out1_bhsr = e1.bhsr;
  assign out1_ssid = e1.ssid;

  // Next pointers/count: flush wins, otherwise push and pop both apply
  always_comb begin
    head_d  = head_q + PW'(pop_n);
    tail_d  = tail_q + PW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Compacted write: in0 at tail, in1 right behind it (or at tail alone)
  always_comb begin
    mem_d = mem_q;
    if (!flush) begin
      if (acc0) begin
        mem_d[tail_q] = '{op: in0_op, bhsr: in0_bhsr, ssid: in0_ssid};
      end
      if (acc1) begin
        mem_d[tail_q + PW'(acc0)] =
          '{op: in1_op, bhsr: in1_bhsr, ssid: in1_ssid};
      end
    end
  end

  // Control state with async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage, intentionally unreset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
